iis_tx_arbiter: RTL and testbench



---
 rtl/iis_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_iis_tx_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iis_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iis_tx_arbiter
// Brief    : Round-robin burst arbiter sharing the IIS TX FIFO write port
//            between two producers. Optional per-channel sent-sample counters
//            are built when IIS_ARB_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module iis_tx_arbiter #(
    parameter int DATA_W = 16,
    parameter int BURST  = 8,
    parameter int CNT_W  = 32
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              enable,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              fifo_full,
    output logic              fifo_wren,
    output logic [DATA_W-1:0] fifo_din,
    output logic [1:0]        grant,
    output logic              busy,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  sent0,
    output logic [CNT_W-1:0]  sent1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam logic [7:0] C_BURST_LAST = 8'(BURST - 1);

    state_t     r_state, w_state_nxt;
    logic       r_last,  w_last_nxt;
    logic [7:0] r_bcnt,  w_bcnt_nxt;

    logic w_in_gnt;
    logic w_cur;
    logic w_cur_valid;
    logic w_oth_valid;
    logic w_accept;
    logic w_xfer;
    logic w_end;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_bcnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    // Outputs are forced to their reset values while preset is high so a
    // write presented in the reset cycle never reaches the FIFO.
    always_comb begin
        w_in_gnt    = (r_state == ST_GNT0) || (r_state == ST_GNT1);
        w_cur       = (r_state == ST_GNT1);
        w_cur_valid = w_cur ? req1_valid : req0_valid;
        w_oth_valid = w_cur ? req0_valid : req1_valid;
        w_accept    = w_in_gnt & enable & ~fifo_full & ~preset;
        w_xfer      = w_accept & w_cur_valid;
        w_end       = ~w_cur_valid | (w_xfer & (r_bcnt == C_BURST_LAST));

        req0_ready  = w_accept & (r_state == ST_GNT0);
        req1_ready  = w_accept & (r_state == ST_GNT1);
        fifo_wren   = w_xfer;
        fifo_din    = '0;
        if (w_in_gnt && !preset) begin
            fifo_din = w_cur ? req1_data : req0_data;
        end
        grant       = preset ? 2'b00
                             : {r_state == ST_GNT1, r_state == ST_GNT0};
        busy        = ~preset & (r_state != ST_IDLE);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_bcnt_nxt  = r_bcnt;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_bcnt_nxt  = 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0_valid && req1_valid) begin
                        w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
                    end else if (req0_valid) begin
                        w_state_nxt = ST_GNT0;
                    end else if (req1_valid) begin
                        w_state_nxt = ST_GNT1;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    if (w_end) begin
                        w_last_nxt = w_cur;
                        w_bcnt_nxt = 8'd0;
                        // Other channel first; otherwise a fresh burst for
                        // the same channel if it still has data.
                        if (w_oth_valid) begin
                            w_state_nxt = w_cur ? ST_GNT0 : ST_GNT1;
                        end else if (w_cur_valid) begin
                            w_state_nxt = r_state;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (w_xfer) begin
                        w_bcnt_nxt = r_bcnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_bcnt_nxt  = 8'd0;
                end
            endcase
        end
    end

`ifdef IIS_ARB_CNT_EN
    logic [CNT_W-1:0] r_sent0;
    logic [CNT_W-1:0] r_sent1;

    // Clear wins over a same-cycle transfer.
    always_ff @(posedge pclk) begin
        if (preset || clr_cnt) begin
            r_sent0 <= '0;
            r_sent1 <= '0;
        end else begin
            if (w_xfer && !w_cur) begin
                r_sent0 <= r_sent0 + CNT_W'(1);
            end
            if (w_xfer && w_cur) begin
                r_sent1 <= r_sent1 + CNT_W'(1);
            end
        end
    end

    assign sent0 = r_sent0;
    assign sent1 = r_sent1;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_cnt;
    assign sent0        = '0;
    assign sent1        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iis_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iis_tx_arbiter
// Brief    : Directed self-checking bench for iis_tx_arbiter (BURST = 8,
//            8-bit counters so wrap-around is reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iis_tx_arbiter;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;
`ifdef IIS_ARB_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic              pclk = 1'b0;
    logic              preset = 1'b1;
    logic              enable = 1'b0;
    logic              req0_valid = 1'b0;
    logic              req1_valid = 1'b0;
    logic [DATA_W-1:0] req0_data = '0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              req0_ready;
    logic              req1_ready;
    logic              fifo_full = 1'b0;
    logic              fifo_wren;
    logic [DATA_W-1:0] fifo_din;
    logic [1:0]        grant;
    logic              busy;
    logic              clr_cnt = 1'b0;
    logic [CNT_W-1:0]  sent0;
    logic [CNT_W-1:0]  sent1;

    int checks = 0;
    int errors = 0;
    int idx0   = 0;
    int idx1   = 0;

    always #5 pclk = ~pclk;

    iis_tx_arbiter #(.DATA_W(DATA_W), .BURST(8), .CNT_W(CNT_W)) dut (
        .pclk(pclk), .preset(preset), .enable(enable),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .fifo_full(fifo_full), .fifo_wren(fifo_wren), .fifo_din(fifo_din),
        .grant(grant), .busy(busy), .clr_cnt(clr_cnt),
        .sent0(sent0), .sent1(sent1)
    );

    logic [21:0] obs;
    assign obs = {grant, busy, fifo_wren, req1_ready, req0_ready, fifo_din};

    function automatic logic [15:0] dat(input int c);
        return (c == 0) ? 16'(idx0) : (16'h8000 | 16'(idx1));
    endfunction

    // Expected {grant,busy,wren,ready1,ready0,din} while channel c is granted.
    function automatic logic [21:0] exp_gnt(input int c, input logic wr, input logic rdy);
        return (c == 0) ? {2'b01, 1'b1, wr, 1'b0, rdy, dat(0)}
                        : {2'b10, 1'b1, wr, rdy, 1'b0, dat(1)};
    endfunction

    // One clock: inputs change just after the rising edge, outputs are
    // observed on the falling edge.
    task automatic drive(input logic en, input logic v0, input logic v1,
                         input logic full, input logic clr, input logic rst);
        @(posedge pclk);
        #1;
        enable     = en;
        req0_valid = v0;
        req1_valid = v1;
        fifo_full  = full;
        clr_cnt    = clr;
        preset     = rst;
        req0_data  = dat(0);
        req1_data  = dat(1);
        @(negedge pclk);
    endtask

    task automatic test_reset;
        drive(0, 0, 0, 0, 0, 1);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL reset_outputs obs=%h exp=%h", obs, 22'd0);
        end
        drive(1, 1, 1, 0, 0, 1);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL reset_forced obs=%h exp=%h", obs, 22'd0);
        end
        checks++;
        if ({sent0, sent1} !== 16'd0) begin
            errors++; $display("FAIL reset_counters sent0=%0d sent1=%0d exp=0", sent0, sent1);
        end
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL idle_no_valid obs=%h exp=%h", obs, 22'd0);
        end
    endtask

    task automatic test_both_stream;
        logic [21:0] e;
        int c;
        drive(1, 1, 1, 0, 0, 0);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL stream_idle obs=%h exp=%h", obs, 22'd0);
        end
        for (int k = 0; k < 24; k++) begin
            c = (k / 8) % 2;
            drive(1, 1, 1, 0, 0, 0);
            e = exp_gnt(c, 1'b1, 1'b1);
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL stream_write k=%0d obs=%h exp=%h", k, obs, e);
            end
            if (c == 0) idx0++; else idx1++;
        end
        drive(1, 0, 0, 0, 0, 0);
        e = exp_gnt(1, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL stream_drop obs=%h exp=%h", obs, e);
        end
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL stream_end_idle obs=%h exp=%h", obs, 22'd0);
        end
        checks++;
        if (sent0 !== (CNT_ON ? 8'd16 : 8'd0) || sent1 !== (CNT_ON ? 8'd8 : 8'd0)) begin
            errors++; $display("FAIL stream_counts sent0=%0d sent1=%0d exp=%0d/%0d",
                               sent0, sent1, CNT_ON ? 16 : 0, CNT_ON ? 8 : 0);
        end
    endtask

    task automatic test_single_ch1;
        logic [21:0] e;
        drive(1, 0, 1, 0, 1, 0);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL ch1_idle obs=%h exp=%h", obs, 22'd0);
        end
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 1, 0, 0, 0);
            e = exp_gnt(1, 1'b1, 1'b1);
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL ch1_write k=%0d obs=%h exp=%h", k, obs, e);
            end
            idx1++;
        end
        drive(1, 0, 0, 0, 0, 0);
        e = exp_gnt(1, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL ch1_drop obs=%h exp=%h", obs, e);
        end
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL ch1_end_idle obs=%h exp=%h", obs, 22'd0);
        end
        checks++;
        if (sent1 !== (CNT_ON ? 8'd20 : 8'd0) || sent0 !== 8'd0) begin
            errors++; $display("FAIL ch1_counts sent0=%0d sent1=%0d exp=0/%0d",
                               sent0, sent1, CNT_ON ? 20 : 0);
        end
    endtask

    task automatic test_fifo_full;
        logic [21:0] e;
        drive(1, 1, 1, 0, 0, 0);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL full_idle obs=%h exp=%h", obs, 22'd0);
        end
        for (int k = 0; k < 13; k++) begin
            drive(1, 1, 1, (k >= 3 && k < 8), 0, 0);
            e = (k >= 3 && k < 8) ? exp_gnt(0, 1'b0, 1'b0) : exp_gnt(0, 1'b1, 1'b1);
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL full_ch0 k=%0d obs=%h exp=%h", k, obs, e);
            end
            if (!(k >= 3 && k < 8)) idx0++;
        end
        drive(1, 1, 1, 0, 0, 0);
        e = exp_gnt(1, 1'b1, 1'b1);
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL full_switch obs=%h exp=%h", obs, e);
        end
        idx1++;
        drive(1, 0, 0, 0, 0, 0);
        e = exp_gnt(1, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL full_drop obs=%h exp=%h", obs, e);
        end
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL full_end_idle obs=%h exp=%h", obs, 22'd0);
        end
    endtask

    task automatic test_enable_drop;
        logic [21:0] e;
        drive(1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 1, 0, 0, 0);
            e = exp_gnt(1, 1'b1, 1'b1);
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL en_ch1_write k=%0d obs=%h exp=%h", k, obs, e);
            end
            idx1++;
        end
        drive(0, 1, 1, 0, 0, 0);
        e = exp_gnt(1, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL en_low obs=%h exp=%h", obs, e);
        end
        drive(1, 1, 1, 0, 0, 0);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL en_idle obs=%h exp=%h", obs, 22'd0);
        end
        drive(1, 1, 1, 0, 0, 0);
        e = exp_gnt(0, 1'b1, 1'b1);
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL en_regrant_ch0 obs=%h exp=%h", obs, e);
        end
        idx0++;
        drive(1, 0, 0, 0, 0, 0);
        e = exp_gnt(0, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL en_drop obs=%h exp=%h", obs, e);
        end
        drive(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_preset_mid;
        logic [21:0] e;
        drive(1, 1, 1, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 1, 0, 0, 0);
            e = exp_gnt(1, 1'b1, 1'b1);
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL rst_ch1_write k=%0d obs=%h exp=%h", k, obs, e);
            end
            idx1++;
        end
        drive(1, 1, 1, 0, 0, 1);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL rst_forced obs=%h exp=%h", obs, 22'd0);
        end
        drive(1, 1, 1, 0, 0, 0);
        checks++;
        if (obs !== 22'd0 || {sent0, sent1} !== 16'd0) begin
            errors++; $display("FAIL rst_after obs=%h sent0=%0d sent1=%0d exp=0", obs, sent0, sent1);
        end
        drive(1, 1, 1, 0, 0, 0);
        e = exp_gnt(0, 1'b1, 1'b1);
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL rst_last_ch0 obs=%h exp=%h", obs, e);
        end
        idx0++;
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_counters;
        logic [21:0] e;
        drive(1, 1, 0, 0, 1, 0);
        for (int k = 0; k < 257; k++) begin
            drive(1, 1, 0, 0, 0, 0);
            e = exp_gnt(0, 1'b1, 1'b1);
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL cnt_write k=%0d obs=%h exp=%h", k, obs, e);
            end
            idx0++;
        end
        checks++;
        if (sent0 !== (CNT_ON ? 8'd0 : 8'd0) || obs[21:20] !== 2'b01) begin
            errors++; $display("FAIL cnt_257 sent0=%0d grant=%b", sent0, obs[21:20]);
        end
        drive(1, 1, 0, 0, 1, 0);
        checks++;
        if (sent0 !== (CNT_ON ? 8'd1 : 8'd0)) begin
            errors++; $display("FAIL cnt_before_clr sent0=%0d exp=%0d", sent0, CNT_ON ? 1 : 0);
        end
        idx0++;
        // Preload to all-ones: 255 writes after the clear above.
        for (int k = 0; k < 255; k++) begin
            drive(1, 1, 0, 0, 0, 0);
            idx0++;
        end
        drive(1, 1, 0, 0, 1, 0);
        checks++;
        if (sent0 !== (CNT_ON ? 8'd255 : 8'd0) || fifo_wren !== 1'b1) begin
            errors++; $display("FAIL cnt_all_ones sent0=%0d wren=%b exp=%0d/1",
                               sent0, fifo_wren, CNT_ON ? 255 : 0);
        end
        idx0++;
        drive(1, 1, 0, 0, 0, 0);
        checks++;
        if (sent0 !== 8'd0) begin
            errors++; $display("FAIL cnt_clr_priority sent0=%0d exp=0", sent0);
        end
        idx0++;
        for (int k = 0; k < 254; k++) begin
            drive(1, 1, 0, 0, 0, 0);
            idx0++;
        end
        drive(1, 1, 0, 0, 0, 0);
        checks++;
        if (sent0 !== (CNT_ON ? 8'd255 : 8'd0)) begin
            errors++; $display("FAIL cnt_pre_wrap sent0=%0d exp=%0d", sent0, CNT_ON ? 255 : 0);
        end
        idx0++;
        drive(1, 1, 0, 0, 0, 0);
        checks++;
        if (sent0 !== 8'd0) begin
            errors++; $display("FAIL cnt_wrap sent0=%0d exp=0", sent0);
        end
        idx0++;
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (sent0 !== (CNT_ON ? 8'd1 : 8'd0) || sent1 !== 8'd0) begin
            errors++; $display("FAIL cnt_after_wrap sent0=%0d sent1=%0d exp=%0d/0",
                               sent0, sent1, CNT_ON ? 1 : 0);
        end
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL cnt_end_idle obs=%h exp=%h", obs, 22'd0);
        end
    endtask

    initial begin
        test_reset();
        test_both_stream();
        test_single_ch1();
        test_fifo_full();
        test_enable_drop();
        test_preset_mid();
        test_counters();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
